ocd_lvl_sched: RTL and testbench

//  Sequences the over-current-detect threshold PWM for the DRSSTC bridge.

---
 rtl/ocd_lvl_sched_if.sv | 21 ++
 rtl/ocd_lvl_sched.sv | 128 ++++++++++++
 tb/tb_ocd_lvl_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ocd_lvl_sched_if.sv
// ocd_lvl_sched_if: run/target/trip inputs and duty/fault status outputs of the OCD threshold sequencer.
interface ocd_lvl_sched_if #(
   parameter int PAR_MAX_VAL = 255,
   parameter int MAX_TRIPS   = 7
);
   localparam int W = $clog2(PAR_MAX_VAL + 1);
   localparam int T = $clog2(MAX_TRIPS + 1);
   logic         en;
   logic [W-1:0] target;
   logic         trip_in;
   logic [W-1:0] pw_par;
   logic         lvl_out;
   logic         period_stb;
   logic         fault;
   logic         lockout;
   logic [T-1:0] trip_cnt;
   modport master (output en, target, trip_in,
                   input  pw_par, lvl_out, period_stb, fault, lockout, trip_cnt);
   modport slave  (input  en, target, trip_in,
                   output pw_par, lvl_out, period_stb, fault, lockout, trip_cnt);
endinterface

// File: rtl/ocd_lvl_sched.sv
// ocd_lvl_sched: soft-ramped, period-aligned OCD threshold PWM with trip hold-off and lockout.
module ocd_lvl_sched #(
   parameter int CLK_MHZ         = 100,
   parameter int PAR_MAX_VAL     = 255,
   parameter int STEP_PERIODS    = 16,
   parameter int HOLDOFF_PERIODS = 1024,
   parameter int MAX_TRIPS       = 7
) (
   input logic clk,
   input logic rst,
   ocd_lvl_sched_if.slave bus
);
   localparam int W  = $clog2(PAR_MAX_VAL + 1);
   localparam int T  = $clog2(MAX_TRIPS + 1);
   localparam int SW = STEP_PERIODS > 1 ? $clog2(STEP_PERIODS) : 1;
   localparam int HW = HOLDOFF_PERIODS > 1 ? $clog2(HOLDOFF_PERIODS) : 1;

   if (PAR_MAX_VAL < 1 || STEP_PERIODS < 1 || HOLDOFF_PERIODS < 1 || MAX_TRIPS < 1 || CLK_MHZ < 1) begin : g_bad_param
      $error("ocd_lvl_sched: illegal parameter value");
   end

   typedef enum logic [2:0] {IDLE, RAMP, HOLD, TRIPPED, LOCKOUT} state_t;

   state_t        state, state_n;
   logic [W-1:0]  cnt, cnt_n, pw, pw_n, tgt_c;
   logic          stb, lvl;
   logic [SW-1:0] step, step_n;
   logic [HW-1:0] hold, hold_n;
   logic [T-1:0]  trips, trips_n, trips_inc;
   logic          s1, s2, s3, ev;
   logic          last_step, last_hold;

   assign cnt_n     = (cnt == '0) ? W'(PAR_MAX_VAL - 1) : cnt - 1'b1;
   assign tgt_c     = ({1'b0, bus.target} > (W+1)'(PAR_MAX_VAL)) ? W'(PAR_MAX_VAL) : bus.target;
   assign trips_inc = (trips == T'(MAX_TRIPS)) ? trips : trips + 1'b1;
   assign last_step = (step == SW'(STEP_PERIODS - 1));
   assign last_hold = (hold == HW'(HOLDOFF_PERIODS - 1));

   // trip_in crosses into clk via s1/s2; ev is the registered rising edge of the synced level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= W'(PAR_MAX_VAL - 1);
         stb   <= 1'b0;
         lvl   <= 1'b0;
         pw    <= '0;
         state <= IDLE;
         step  <= '0;
         hold  <= '0;
         trips <= '0;
         s1    <= 1'b0;
         s2    <= 1'b0;
         s3    <= 1'b0;
         ev    <= 1'b0;
      end else begin
         cnt   <= cnt_n;
         stb   <= (cnt_n == '0);
         lvl   <= (cnt_n < pw_n);
         pw    <= pw_n;
         state <= state_n;
         step  <= step_n;
         hold  <= hold_n;
         trips <= trips_n;
         s1    <= bus.trip_in;
         s2    <= s1;
         s3    <= s2;
         ev    <= s2 & ~s3;
      end
   end

   // pw only moves on stb edges so the new duty lands exactly at the counter reload
   always_comb begin
      state_n = state;
      pw_n    = pw;
      step_n  = step;
      hold_n  = hold;
      trips_n = trips;
      if (!bus.en) begin
         state_n = IDLE;
         trips_n = '0;
         step_n  = '0;
         hold_n  = '0;
         pw_n    = stb ? '0 : pw;
      end else begin
         case (state)
            IDLE: begin
               state_n = RAMP;
               trips_n = '0;
               step_n  = '0;
               pw_n    = stb ? '0 : pw;
            end
            RAMP, HOLD: begin
               if (ev) begin
                  trips_n = trips_inc;
                  state_n = (trips_inc == T'(MAX_TRIPS)) ? LOCKOUT : TRIPPED;
                  hold_n  = '0;
               end else if (state == RAMP) begin
                  if (stb) begin
                     step_n = last_step ? '0 : step + 1'b1;
                     pw_n   = !last_step ? pw : (pw < tgt_c) ? pw + 1'b1 : tgt_c;
                  end
                  state_n = (pw_n == tgt_c) ? HOLD : RAMP;
               end else if (stb) begin
                  pw_n    = (tgt_c < pw) ? tgt_c : pw;
                  state_n = (tgt_c > pw) ? RAMP : HOLD;
                  step_n  = '0;
               end
            end
            TRIPPED: begin
               if (stb) begin
                  hold_n  = last_hold ? '0 : hold + 1'b1;
                  pw_n    = last_hold ? '0 : pw;
                  state_n = last_hold ? RAMP : TRIPPED;
                  step_n  = '0;
               end
            end
            LOCKOUT: pw_n = stb ? '0 : pw;
            default: state_n = IDLE;
         endcase
      end
   end

   assign bus.pw_par     = pw;
   assign bus.lvl_out    = lvl;
   assign bus.period_stb = stb;
   assign bus.fault      = (state == TRIPPED) || (state == LOCKOUT);
   assign bus.lockout    = (state == LOCKOUT);
   assign bus.trip_cnt   = trips;
endmodule

// File: tb/tb_ocd_lvl_sched.sv
// tb_ocd_lvl_sched: directed scenarios with literal expectations, then random traffic against a behavioural model.
module tb_ocd_lvl_sched;
   localparam int PM = 15, SP = 2, HO = 4, MT = 3;
   localparam int S_IDLE = 0, S_RAMP = 1, S_HOLD = 2, S_TRIP = 3, S_LOCK = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;

   ocd_lvl_sched_if #(.PAR_MAX_VAL(PM), .MAX_TRIPS(MT)) bus ();
   ocd_lvl_sched #(.CLK_MHZ(100), .PAR_MAX_VAL(PM), .STEP_PERIODS(SP),
                   .HOLDOFF_PERIODS(HO), .MAX_TRIPS(MT)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // model state: edges since reset, mode, duty, trip count, stbs in current ramp, stbs held off
   int m_n = 0, m_st = S_IDLE, m_pw = 0, m_trips = 0, m_rs = 0, m_held = 0;
   logic [3:0] m_th = '0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_n = 0; m_st = S_IDLE; m_pw = 0; m_trips = 0; m_rs = 0; m_held = 0; m_th = '0;
      end else begin
         automatic bit stb = ((PM - 1 - (m_n % PM)) == 0);
         automatic int tg = (int'(bus.target) > PM) ? PM : int'(bus.target);
         automatic bit ev = m_th[2] && !m_th[3];
         if (!bus.en) begin
            if (stb) m_pw = 0;
            m_st = S_IDLE; m_trips = 0;
         end else if (m_st == S_IDLE) begin
            if (stb) m_pw = 0;
            m_st = S_RAMP; m_trips = 0; m_rs = 0;
         end else if ((m_st == S_RAMP || m_st == S_HOLD) && ev) begin
            m_trips = (m_trips < MT) ? m_trips + 1 : MT;
            m_st = (m_trips == MT) ? S_LOCK : S_TRIP;
            m_held = 0;
         end else if (m_st == S_RAMP) begin
            if (stb) begin
               m_rs++;
               if (m_rs % SP == 0) m_pw = (m_pw < tg) ? m_pw + 1 : tg;
            end
            if (m_pw == tg) m_st = S_HOLD;
         end else if (m_st == S_HOLD && stb) begin
            if (tg < m_pw) m_pw = tg;
            else if (tg > m_pw) begin m_st = S_RAMP; m_rs = 0; end
         end else if (m_st == S_TRIP && stb) begin
            m_held++;
            if (m_held == HO) begin m_st = S_RAMP; m_pw = 0; m_rs = 0; end
         end else if (m_st == S_LOCK && stb) begin
            m_pw = 0;
         end
         m_th = {m_th[2:0], bus.trip_in};
         m_n++;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         automatic int ecnt = PM - 1 - (m_n % PM);
         automatic bit e_stb = (ecnt == 0);
         automatic bit e_lvl = (ecnt < m_pw);
         automatic bit e_flt = (m_st == S_TRIP) || (m_st == S_LOCK);
         automatic bit e_lck = (m_st == S_LOCK);
         total++;
         if (int'(bus.pw_par) != m_pw || bus.lvl_out != e_lvl || bus.period_stb != e_stb ||
             bus.fault != e_flt || bus.lockout != e_lck || int'(bus.trip_cnt) != m_trips) begin
            bad++;
            $display("FAIL model t=%0t (dut/exp) pw=%0d/%0d lvl=%0b/%0b stb=%0b/%0b fault=%0b/%0b lock=%0b/%0b trips=%0d/%0d",
                     $time, bus.pw_par, m_pw, bus.lvl_out, e_lvl, bus.period_stb, e_stb,
                     bus.fault, e_flt, bus.lockout, e_lck, bus.trip_cnt, m_trips);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic trip_pulse();
      bus.trip_in = 1'b1;
      cyc(2);
      bus.trip_in = 1'b0;
      cyc(2);
   endtask

   task automatic duty(input string name, input int exp);
      int hi = 0;
      for (int i = 0; i < PM; i++) begin
         cyc(1);
         hi += int'(bus.lvl_out);
      end
      chk(name, hi, exp);
   endtask

   initial begin
      int tp = 0;
      bus.en = 1'b0;
      bus.target = '0;
      bus.trip_in = 1'b0;
      cyc(3);
      rst = 1'b0;
      chk("rst_pw", int'(bus.pw_par), 0);
      chk("rst_stb", int'(bus.period_stb), 0);
      chk("rst_flt", int'(bus.fault), 0);
      chk("rst_trips", int'(bus.trip_cnt), 0);
      bus.en = 1'b1;
      bus.target = 4'd5;
      cyc(29);
      chk("ramp_e29", int'(bus.pw_par), 0);
      cyc(1);
      chk("ramp_e30", int'(bus.pw_par), 1);
      cyc(119);
      chk("ramp_e149", int'(bus.pw_par), 4);
      cyc(1);
      chk("ramp_e150", int'(bus.pw_par), 5);
      duty("duty5", 5);
      bus.target = 4'd2;
      cyc(15);
      chk("drop_to2", int'(bus.pw_par), 2);
      bus.target = 4'd15;
      cyc(420);
      chk("ramp_full", int'(bus.pw_par), 15);
      duty("duty15", 15);
      bus.trip_in = 1'b1;
      cyc(1);
      chk("trip_e0", int'(bus.fault), 0);
      cyc(1);
      bus.trip_in = 1'b0;
      chk("trip_e1", int'(bus.fault), 0);
      cyc(1);
      chk("trip_e2", int'(bus.fault), 0);
      cyc(1);
      chk("trip_e3", int'(bus.fault), 1);
      chk("trip_cnt1", int'(bus.trip_cnt), 1);
      cyc(5);
      trip_pulse();
      cyc(36);
      chk("held_flt", int'(bus.fault), 1);
      chk("held_pw", int'(bus.pw_par), 15);
      chk("ignored_trip", int'(bus.trip_cnt), 1);
      cyc(15);
      chk("rearm_flt", int'(bus.fault), 0);
      chk("rearm_pw", int'(bus.pw_par), 0);
      trip_pulse();
      chk("trip_cnt2", int'(bus.trip_cnt), 2);
      cyc(60);
      trip_pulse();
      chk("lock", int'(bus.lockout), 1);
      chk("trip_cnt3", int'(bus.trip_cnt), 3);
      cyc(15);
      chk("lock_pw", int'(bus.pw_par), 0);
      bus.en = 1'b0;
      cyc(1);
      chk("unlock", int'(bus.lockout), 0);
      chk("unlock_trips", int'(bus.trip_cnt), 0);
      bus.en = 1'b1;
      cyc(40);
      bus.en = 1'b0;
      bus.trip_in = 1'b1;
      cyc(2);
      bus.trip_in = 1'b0;
      cyc(4);
      chk("en_beats_trip", int'(bus.fault), 0);
      chk("en_beats_trips", int'(bus.trip_cnt), 0);
      bus.en = 1'b1;
      bus.target = 4'd9;
      cyc(100);
      chk("pre_rst_pw", int'(bus.pw_par != '0), 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_pw", int'(bus.pw_par), 0);
      chk("arst_lvl", int'(bus.lvl_out), 0);
      chk("arst_stb", int'(bus.period_stb), 0);
      @(negedge clk);
      rst = 1'b0;
      cyc(13);
      chk("arst_cnt13", int'(bus.period_stb), 0);
      cyc(1);
      chk("arst_cnt14", int'(bus.period_stb), 1);
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 4999) == 0);
         if ($urandom_range(0, 299) == 0) bus.target = 4'($urandom_range(0, 15));
         if (bus.en && $urandom_range(0, 399) == 0) bus.en = 1'b0;
         else if (!bus.en && $urandom_range(0, 9) == 0) bus.en = 1'b1;
         if (tp == 0 && $urandom_range(0, 149) == 0) tp = $urandom_range(1, 3);
         bus.trip_in = (tp > 0);
         if (tp > 0) tp--;
      end
      rst = 1'b0;
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
